// File: rtl/sreg_wb_arbiter.sv
// sreg_wb_arbiter
// Shares the scalar register file write port among NUM_REQ writeback requesters.
// Round-robin valid/ready arbitration feeds a one-cycle registered write stage.
// A per-register busy scoreboard is set at issue and cleared at writeback. It
// drives the RAW/WAW hazard queries.
// Optional feature: define SREG_WB_FWD_EN to forward the value being written this
// cycle to rs1/rs2 consumers. The busy flag for that source is then masked.
// Without the macro the forward outputs are tied to zero.
module sreg_wb_arbiter #(
    parameter int DATA_WIDTH = 32,
    parameter int NUM_REQ    = 3,
    parameter int REG_COUNT  = 32
) (
    input  logic                                clk,
    input  logic                                rst_n,
    input  logic [NUM_REQ-1:0]                  req_valid_i,
    output logic [NUM_REQ-1:0]                  req_ready_o,
    input  logic [NUM_REQ-1:0][4:0]             req_rd_addr_i,
    input  logic [NUM_REQ-1:0][DATA_WIDTH-1:0]  req_data_i,
    output logic [4:0]                          rd_addr_o,
    output logic [DATA_WIDTH-1:0]               rd_data_o,
    output logic                                reg_write_en_o,
    input  logic                                issue_valid_i,
    input  logic [4:0]                          issue_rd_i,
    input  logic [4:0]                          rs1_addr_i,
    input  logic [4:0]                          rs2_addr_i,
    output logic                                rs1_busy_o,
    output logic                                rs2_busy_o,
    output logic                                rd_busy_o,
    output logic [DATA_WIDTH-1:0]               rs1_fwd_data_o,
    output logic [DATA_WIDTH-1:0]               rs2_fwd_data_o
);

    localparam int PTR_W = $clog2(NUM_REQ);

    logic [PTR_W-1:0]      ptr_q;
    logic [PTR_W-1:0]      ptr_d;
    logic [PTR_W-1:0]      cand_idx;
    logic [PTR_W-1:0]      grant_idx;
    logic                  grant_any;
    logic [NUM_REQ-1:0]    grant_oh;
    logic [4:0]            sel_addr;
    logic [DATA_WIDTH-1:0] sel_data;
    logic [REG_COUNT-1:0]  busy_q;
    logic [REG_COUNT-1:0]  busy_d;
    logic                  rs1_sb_busy;
    logic                  rs2_sb_busy;

    // Ring index (base + k) mod NUM_REQ, with k < NUM_REQ.
    function automatic logic [PTR_W-1:0] ring_add(input logic [PTR_W-1:0] base, input int k);
        int s;
        s = int'(base) + k;
        if (s >= NUM_REQ) begin
            s = s - NUM_REQ;
        end
        return PTR_W'(s);
    endfunction

    // Scoreboard lookup. x0 and registers beyond REG_COUNT are never busy.
    function automatic logic sb_lookup(input logic [REG_COUNT-1:0] b, input logic [4:0] addr);
        logic hit;
        hit = 1'b0;
        for (int r = 1; r < REG_COUNT; r++) begin
            if (5'(r) == addr) begin
                hit = b[r];
            end
        end
        return hit;
    endfunction

    // Round-robin scan from the pointer upward with wrap; the first valid requester wins.
    always_comb begin
        grant_any = 1'b0;
        grant_idx = '0;
        cand_idx  = '0;
        grant_oh  = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            cand_idx = ring_add(ptr_q, k);
            if (!grant_any && req_valid_i[cand_idx]) begin
                grant_any = 1'b1;
                grant_idx = cand_idx;
            end
        end
        if (grant_any) begin
            grant_oh[grant_idx] = 1'b1;
        end
    end

    // The write stage drains every cycle, so any grant is a transfer.
    // Ready is gated low while reset is held.
    assign req_ready_o = rst_n ? grant_oh : '0;
    assign sel_addr    = req_rd_addr_i[grant_idx];
    assign sel_data    = req_data_i[grant_idx];

    // Next pointer: one past the transferring requester; held on idle cycles.
    always_comb begin
        ptr_d = ptr_q;
        if (grant_any) begin
            ptr_d = (grant_idx == PTR_W'(NUM_REQ - 1)) ? '0 : grant_idx + 1'b1;
        end
    end

    // Pointer register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

    // Registered write stage. A write to x0 is accepted but not written.
    // The address and data outputs keep their last value when no write happens.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            reg_write_en_o <= 1'b0;
            rd_addr_o      <= '0;
            rd_data_o      <= '0;
        end else begin
            reg_write_en_o <= grant_any && (sel_addr != 5'd0);
            if (grant_any && (sel_addr != 5'd0)) begin
                rd_addr_o <= sel_addr;
                rd_data_o <= sel_data;
            end
        end
    end

    // Scoreboard next state. A new producer's set overrides a same-cycle writeback clear.
    always_comb begin
        busy_d = busy_q;
        busy_d[0] = 1'b0;
        for (int r = 1; r < REG_COUNT; r++) begin
            if (reg_write_en_o && (rd_addr_o == 5'(r))) begin
                busy_d[r] = 1'b0;
            end
            if (issue_valid_i && (issue_rd_i == 5'(r))) begin
                busy_d[r] = 1'b1;
            end
        end
    end

    // Scoreboard register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_q <= '0;
        end else begin
            busy_q <= busy_d;
        end
    end

    assign rs1_sb_busy = sb_lookup(busy_q, rs1_addr_i);
    assign rs2_sb_busy = sb_lookup(busy_q, rs2_addr_i);
    assign rd_busy_o   = sb_lookup(busy_q, issue_rd_i);

`ifdef SREG_WB_FWD_EN
    logic rs1_hit;
    logic rs2_hit;

    // A source matching the write in progress takes the value being written.
    always_comb begin
        rs1_hit        = reg_write_en_o && (rd_addr_o == rs1_addr_i) && (rs1_addr_i != 5'd0);
        rs2_hit        = reg_write_en_o && (rd_addr_o == rs2_addr_i) && (rs2_addr_i != 5'd0);
        rs1_busy_o     = rs1_sb_busy && !rs1_hit;
        rs2_busy_o     = rs2_sb_busy && !rs2_hit;
        rs1_fwd_data_o = rs1_hit ? rd_data_o : '0;
        rs2_fwd_data_o = rs2_hit ? rd_data_o : '0;
    end
`else
    // No bypass: the consumer waits until the regfile holds the value.
    always_comb begin
        rs1_busy_o     = rs1_sb_busy;
        rs2_busy_o     = rs2_sb_busy;
        rs1_fwd_data_o = '0;
        rs2_fwd_data_o = '0;
    end
`endif

endmodule

// File: tb/tb_sreg_wb_arbiter.sv
// Testbench for sreg_wb_arbiter: directed scenarios followed by randomized traffic.
// All results are checked against a behavioural model.
module tb_sreg_wb_arbiter;

    localparam int N  = 3;
    localparam int DW = 32;

    logic                  clk = 1'b0;
    logic                  rst_n = 1'b1;
    logic [N-1:0]          req_valid_i;
    logic [N-1:0]          req_ready_o;
    logic [N-1:0][4:0]     req_rd_addr_i;
    logic [N-1:0][DW-1:0]  req_data_i;
    logic [4:0]            rd_addr_o;
    logic [DW-1:0]         rd_data_o;
    logic                  reg_write_en_o;
    logic                  issue_valid_i;
    logic [4:0]            issue_rd_i;
    logic [4:0]            rs1_addr_i;
    logic [4:0]            rs2_addr_i;
    logic                  rs1_busy_o;
    logic                  rs2_busy_o;
    logic                  rd_busy_o;
    logic [DW-1:0]         rs1_fwd_data_o;
    logic [DW-1:0]         rs2_fwd_data_o;

    always #5 clk = ~clk;

    sreg_wb_arbiter #(.DATA_WIDTH(DW), .NUM_REQ(N), .REG_COUNT(32)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .req_valid_i    (req_valid_i),
        .req_ready_o    (req_ready_o),
        .req_rd_addr_i  (req_rd_addr_i),
        .req_data_i     (req_data_i),
        .rd_addr_o      (rd_addr_o),
        .rd_data_o      (rd_data_o),
        .reg_write_en_o (reg_write_en_o),
        .issue_valid_i  (issue_valid_i),
        .issue_rd_i     (issue_rd_i),
        .rs1_addr_i     (rs1_addr_i),
        .rs2_addr_i     (rs2_addr_i),
        .rs1_busy_o     (rs1_busy_o),
        .rs2_busy_o     (rs2_busy_o),
        .rd_busy_o      (rd_busy_o),
        .rs1_fwd_data_o (rs1_fwd_data_o),
        .rs2_fwd_data_o (rs2_fwd_data_o)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model state
    int            m_ptr;
    bit            m_busy [32];
    bit            m_wen;
    logic [4:0]    m_addr;
    logic [DW-1:0] m_data;
    int            cur_g;

    // Stimulus for the current cycle
    logic [N-1:0]         in_v;
    logic [N-1:0][4:0]    in_a;
    logic [N-1:0][DW-1:0] in_d;
    logic                 in_iv;
    logic [4:0]           in_ird;
    logic [4:0]           in_q1;
    logic [4:0]           in_q2;

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    function automatic logic exp_busy(input logic [4:0] q);
        if (q == 5'd0) return 1'b0;
`ifdef SREG_WB_FWD_EN
        if (m_wen && m_addr == q) return 1'b0;
`endif
        return m_busy[q];
    endfunction

    function automatic logic [DW-1:0] exp_fwd(input logic [4:0] q);
`ifdef SREG_WB_FWD_EN
        if (q != 5'd0 && m_wen && m_addr == q) return m_data;
`endif
        return '0;
    endfunction

    task automatic clear_in();
        in_v = '0; in_a = '0; in_d = '0;
        in_iv = 1'b0; in_ird = '0; in_q1 = '0; in_q2 = '0;
    endtask

    task automatic model_reset();
        m_ptr = 0; m_wen = 1'b0; m_addr = '0; m_data = '0;
        for (int r = 0; r < 32; r++) m_busy[r] = 1'b0;
    endtask

    // Drive the stimulus at negedge, then check every output against the model.
    task automatic drive_check();
        logic [N-1:0] exp_rdy;
        @(negedge clk);
        req_valid_i = in_v; req_rd_addr_i = in_a; req_data_i = in_d;
        issue_valid_i = in_iv; issue_rd_i = in_ird;
        rs1_addr_i = in_q1; rs2_addr_i = in_q2;
        #1;
        cur_g = -1;
        for (int k = 0; k < N; k++) begin
            int idx;
            idx = (m_ptr + k) % N;
            if (cur_g < 0 && in_v[idx]) cur_g = idx;
        end
        exp_rdy = '0;
        if (cur_g >= 0) exp_rdy[cur_g] = 1'b1;
        check("ready", req_ready_o, exp_rdy);
        check("wen", reg_write_en_o, m_wen);
        check("rd_addr", rd_addr_o, m_addr);
        check("rd_data", rd_data_o, m_data);
        check("rs1_busy", rs1_busy_o, exp_busy(in_q1));
        check("rs2_busy", rs2_busy_o, exp_busy(in_q2));
        check("rd_busy", rd_busy_o, (in_ird != 5'd0) ? m_busy[in_ird] : 1'b0);
        check("rs1_fwd", rs1_fwd_data_o, exp_fwd(in_q1));
        check("rs2_fwd", rs2_fwd_data_o, exp_fwd(in_q2));
    endtask

    // Advance the model across the posedge using the stimulus held during it.
    task automatic commit();
        @(posedge clk);
        if (m_wen) m_busy[m_addr] = 1'b0;
        if (in_iv && in_ird != 5'd0) m_busy[in_ird] = 1'b1;
        m_wen = 1'b0;
        if (cur_g >= 0) begin
            m_ptr = (cur_g + 1) % N;
            if (in_a[cur_g] != 5'd0) begin
                m_wen  = 1'b1;
                m_addr = in_a[cur_g];
                m_data = in_d[cur_g];
            end
        end
    endtask

    task automatic step();
        drive_check();
        commit();
    endtask

    // Assert reset with requests pending; every output must drop to zero immediately.
    task automatic do_reset();
        rst_n = 1'b0;
        req_valid_i = '1;
        #1;
        check("rst_ready", req_ready_o, '0);
        check("rst_wen", reg_write_en_o, 1'b0);
        check("rst_addr", rd_addr_o, '0);
        check("rst_data", rd_data_o, '0);
        check("rst_rs1_busy", rs1_busy_o, 1'b0);
        check("rst_rs2_busy", rs2_busy_o, 1'b0);
        check("rst_rs1_fwd", rs1_fwd_data_o, '0);
        check("rst_rs2_fwd", rs2_fwd_data_o, '0);
        model_reset();
        @(posedge clk);
        @(negedge clk);
        req_valid_i = '0; issue_valid_i = 1'b0; issue_rd_i = '0;
        rst_n = 1'b1;
    endtask

    logic [N-1:0]         h_v;
    logic [N-1:0][4:0]    h_a;
    logic [N-1:0][DW-1:0] h_d;

    initial begin
        req_valid_i = '0; req_rd_addr_i = '0; req_data_i = '0;
        issue_valid_i = 1'b0; issue_rd_i = '0; rs1_addr_i = '0; rs2_addr_i = '0;
        clear_in();
        model_reset();
        cur_g = -1;
        #2 rst_n = 1'b0;
        @(negedge clk);
        do_reset();

        // Single request: issue rd5, then requester 1 writes 0xDEAD to r5
        clear_in(); in_iv = 1'b1; in_ird = 5'd5; in_q1 = 5'd5;
        step();
        clear_in(); in_v = 3'b010; in_a[1] = 5'd5; in_d[1] = 32'hDEAD; in_q1 = 5'd5;
        drive_check();
        check("single_ready", req_ready_o, 3'b010);
        check("single_busy_set", rs1_busy_o, 1'b1);
        commit();
        clear_in(); in_q1 = 5'd5;
        drive_check();
        check("single_wen", reg_write_en_o, 1'b1);
        check("single_addr", rd_addr_o, 5'd5);
        check("single_data", rd_data_o, 32'hDEAD);
        commit();
        drive_check();
        check("single_busy_clr", rs1_busy_o, 1'b0);
        commit();

        // Round-robin from pointer 0 with every requester valid continuously
        @(negedge clk);
        do_reset();
        for (int c = 0; c < 7; c++) begin
            clear_in();
            if (c < 6) begin
                in_v = '1;
                for (int i = 0; i < N; i++) begin
                    in_a[i] = 5'(10 + i);
                    in_d[i] = DW'(c * 16 + i);
                end
            end
            drive_check();
            if (c < 6) check("rr_grant", req_ready_o, 3'b001 << (c % 3));
            if (c > 0) check("rr_wen", reg_write_en_o, 1'b1);
            commit();
        end

        // Write to x0 is accepted and dropped; the pointer still advances
        clear_in(); in_v = 3'b001; in_a[0] = 5'd0; in_d[0] = 32'h1234;
        drive_check();
        check("x0_ready", req_ready_o, 3'b001);
        commit();
        clear_in();
        drive_check();
        check("x0_wen", reg_write_en_o, 1'b0);
        commit();
        clear_in(); in_v = '1; in_a[0] = 5'd1; in_a[1] = 5'd2; in_a[2] = 5'd4;
        drive_check();
        check("x0_ptr", req_ready_o, 3'b010);
        commit();
        clear_in();
        step();

        // Scoreboard: r7 set, held through its write, then re-set on the clearing edge
        clear_in(); in_iv = 1'b1; in_ird = 5'd7; in_q1 = 5'd7;
        step();
        clear_in(); in_q1 = 5'd7;
        drive_check();
        check("sb7_set", rs1_busy_o, 1'b1);
        commit();
        clear_in(); in_v = 3'b100; in_a[2] = 5'd7; in_d[2] = 32'h77; in_q1 = 5'd7;
        drive_check();
        check("sb7_hold", rs1_busy_o, 1'b1);
        commit();
        clear_in(); in_iv = 1'b1; in_ird = 5'd7; in_q1 = 5'd7;
        drive_check();
        check("sb7_wen", reg_write_en_o, 1'b1);
        commit();
        clear_in(); in_q1 = 5'd7;
        drive_check();
        check("sb7_reissue", rs1_busy_o, 1'b1);
        commit();

        // Forwarding of r9, then an asynchronous reset while the write is in flight
        clear_in(); in_iv = 1'b1; in_ird = 5'd3;
        step();
        clear_in(); in_iv = 1'b1; in_ird = 5'd9;
        step();
        clear_in(); in_v = 3'b001; in_a[0] = 5'd9; in_d[0] = 32'hCAFE;
        step();
        clear_in(); in_q1 = 5'd3; in_q2 = 5'd9;
        drive_check();
        check("fwd_wen", reg_write_en_o, 1'b1);
        check("rst_pre_busy3", rs1_busy_o, 1'b1);
`ifdef SREG_WB_FWD_EN
        check("fwd_busy", rs2_busy_o, 1'b0);
        check("fwd_data", rs2_fwd_data_o, 32'hCAFE);
`else
        check("nofwd_busy", rs2_busy_o, 1'b1);
        check("nofwd_data", rs2_fwd_data_o, '0);
`endif
        #1;
        do_reset();
        clear_in(); in_v = '1; in_a[0] = 5'd1; in_a[1] = 5'd2; in_a[2] = 5'd3; in_q1 = 5'd3;
        drive_check();
        check("rst_ptr", req_ready_o, 3'b001);
        commit();
        clear_in();
        step();

        // Randomized traffic; requesters hold their request until it transfers
        h_v = '0; h_a = '0; h_d = '0; cur_g = -1;
        for (int c = 0; c < 600; c++) begin
            for (int i = 0; i < N; i++) begin
                if (!(h_v[i] && cur_g != i)) begin
                    h_v[i] = ($urandom_range(0, 9) < 6);
                    h_a[i] = 5'($urandom_range(0, 7));
                    h_d[i] = $urandom;
                end
            end
            in_v = h_v; in_a = h_a; in_d = h_d;
            in_iv  = ($urandom_range(0, 3) == 0);
            in_ird = 5'($urandom_range(0, 7));
            in_q1  = 5'($urandom_range(0, 7));
            in_q2  = 5'($urandom_range(0, 7));
            step();
            if (c == 300) begin
                @(negedge clk);
                do_reset();
                h_v = '0;
                cur_g = -1;
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
